// File: rtl/elastic_buffer_pkg.sv
// rtl/elastic_buffer_pkg.sv - shared widths and pointer helpers for elastic_buffer
package elastic_buffer_pkg;

    localparam int STAT_W = 32;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// rtl/elastic_buffer_mem.sv - DEPTH x DW register array, registered write, asynchronous read
module elastic_buffer_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer.sv
// rtl/elastic_buffer.sv - DEPTH-entry valid/ready elastic buffer with optional bypass; stats under ELASTIC_BUFFER_STATS_EN
module elastic_buffer
    import elastic_buffer_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DW-1:0]                 data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DW-1:0]                 data_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
`ifdef ELASTIC_BUFFER_STATS_EN
    ,
    output logic [STAT_W-1:0]             stall_cnt_o,
    output logic [cnt_width(DEPTH)-1:0]   max_count_o
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam bit BYP = (BYPASS != 0);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [DW-1:0] mem_rdata;
    logic          empty;
    logic          bypass_hit;
    logic          push;
    logic          pop;
    logic          store;
    logic          drain;

    elastic_buffer_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_comb begin
        empty      = (count == '0);
        ready_o    = rst_n && (count < FULL);
        bypass_hit = BYP && empty && valid_i && rst_n;
        valid_o    = rst_n && (!empty || bypass_hit);
        data_o     = '0;
        if (valid_o) begin
            data_o = empty ? data_i : mem_rdata;
        end
        push  = valid_i && ready_o;
        pop   = valid_o && ready_i;
        // A bypassed beat taken downstream in the same cycle never touches storage.
        store = push && !(bypass_hit && ready_i);
        drain = pop && !empty;
        count_nxt = count;
        if (store && !drain) begin
            count_nxt = count + CW'(1);
        end else if (drain && !store) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (store) begin
                wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (drain) begin
                rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
            end
        end
    end

    assign count_o = count;

`ifdef ELASTIC_BUFFER_STATS_EN
    logic [STAT_W-1:0] stall_cnt;
    logic [CW-1:0]     max_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            max_count <= '0;
        end else begin
            if (valid_o && !ready_i && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
            if (count_nxt > max_count) begin
                max_count <= count_nxt;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign max_count_o = max_count;
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// tb/tb_elastic_buffer.sv - self-checking bench for elastic_buffer (three configurations)
module tb_elastic_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    logic [7:0] a_data_i, a_data_o;
    logic [2:0] a_count_o;
    logic       b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [7:0] b_data_i, b_data_o;
    logic [1:0] b_count_o;
    logic       c_valid_i, c_ready_o, c_valid_o, c_ready_i;
    logic [7:0] c_data_i, c_data_o;
    logic [1:0] c_count_o;
`ifdef ELASTIC_BUFFER_STATS_EN
    logic [31:0] a_stall, b_stall, c_stall;
    logic [2:0]  a_max;
    logic [1:0]  b_max, c_max;
`endif

    elastic_buffer #(.DW(8), .DEPTH(4), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .count_o(a_count_o)
`ifdef ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(a_stall), .max_count_o(a_max)
`endif
    );

    elastic_buffer #(.DW(8), .DEPTH(3), .BYPASS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .count_o(b_count_o)
`ifdef ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(b_stall), .max_count_o(b_max)
`endif
    );

    elastic_buffer #(.DW(8), .DEPTH(2), .BYPASS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .valid_i(c_valid_i), .ready_o(c_ready_o), .data_i(c_data_i),
        .valid_o(c_valid_o), .ready_i(c_ready_i), .data_o(c_data_o), .count_o(c_count_o)
`ifdef ELASTIC_BUFFER_STATS_EN
        , .stall_cnt_o(c_stall), .max_count_o(c_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_rdy;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    int         b_cnt = 0, b_out_n = 0, b_peak = 0;
    logic [7:0] b_src[$], b_sb[$];
    int         c_cnt = 0, c_out_n = 0;
    logic [7:0] c_src[$], c_sb[$];

    // One cycle on the DEPTH=3 bypass buffer against an independent occupancy model.
    task automatic b_step(input logic want_v, input logic r);
        logic push, mv, stored, drained;
        @(negedge clk);
        b_valid_i = want_v && (b_src.size() > 0);
        b_data_i  = (b_src.size() > 0) ? b_src[0] : 8'h00;
        b_ready_i = r;
        #1;
        mv = (b_cnt > 0) || b_valid_i;
        chk("b_count", 32'(b_count_o), b_cnt);
        chk("b_ready", 32'(b_ready_o), 32'(b_cnt < 3));
        chk("b_valid", 32'(b_valid_o), 32'(mv));
        push = b_valid_i && (b_cnt < 3);
        if (push) begin
            b_sb.push_back(b_data_i);
            void'(b_src.pop_front());
        end
        if (mv && r) begin
            chk("b_data", 32'(b_data_o), 32'(b_sb.pop_front()));
            b_out_n++;
        end else if (!mv) begin
            chk("b_idle_data", 32'(b_data_o), 0);
        end
        stored  = push && !((b_cnt == 0) && r);
        drained = mv && r && (b_cnt > 0);
        b_cnt   = b_cnt + int'(stored) - int'(drained);
        if (b_cnt > b_peak) b_peak = b_cnt;
    endtask

    // One cycle on the DEPTH=2 registered buffer.
    task automatic c_step(input logic want_v, input logic r);
        logic push, mv;
        @(negedge clk);
        c_valid_i = want_v && (c_src.size() > 0);
        c_data_i  = (c_src.size() > 0) ? c_src[0] : 8'h00;
        c_ready_i = r;
        #1;
        mv = (c_cnt > 0);
        chk("c_count", 32'(c_count_o), c_cnt);
        chk("c_valid", 32'(c_valid_o), 32'(mv));
        push = c_valid_i && (c_cnt < 2);
        if (push) begin
            c_sb.push_back(c_data_i);
            void'(c_src.pop_front());
        end
        if (mv && r) begin
            chk("c_data", 32'(c_data_o), 32'(c_sb.pop_front()));
            c_out_n++;
        end
        c_cnt = c_cnt + int'(push) - int'(mv && r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_valid_i = 0; a_data_i = 0; a_ready_i = 0;
        b_valid_i = 0; b_data_i = 0; b_ready_i = 0;
        c_valid_i = 0; c_data_i = 0; c_ready_i = 0;

        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 3'd0});
        vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 3'd0});
        vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 3'd1});
        vecs.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 1'b1, 3'd2});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 3'd2});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0});

        #1;
        chk("rst_a", {a_valid_o, a_ready_o, a_data_o, a_count_o}, 0);
        chk("rst_b", {b_valid_o, b_ready_o, b_data_o, b_count_o}, 0);
        chk("rst_c", {c_valid_o, c_ready_o, c_data_o, c_count_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass / storage vectors on the DEPTH=4 buffer
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_valid_i = vecs[i].v;
            a_data_i  = vecs[i].d;
            a_ready_i = vecs[i].r;
            #1;
            chk($sformatf("vec%0d", i), {a_valid_o, a_data_o, a_ready_o, a_count_o},
                {vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_rdy, vecs[i].exp_cnt});
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid_i = 1'b1;
            a_data_i  = 8'h11 * 8'(i + 1);
            a_ready_i = 1'b0;
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        chk("fill3_count", 32'(a_count_o), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_a", {a_valid_o, a_ready_o, a_data_o, a_count_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_valid_i = 1'b1; a_data_i = 8'hA5; a_ready_i = 1'b0;
        #1;
        chk("post_rst_bypass", {a_valid_o, a_data_o, a_ready_o}, {1'b1, 8'hA5, 1'b1});
        @(negedge clk);
        a_data_i = 8'hB6; a_ready_i = 1'b1;
        #1;
        chk("post_rst_first", {a_valid_o, a_data_o, a_count_o}, {1'b1, 8'hA5, 3'd1});
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        chk("post_rst_second", {a_valid_o, a_data_o, a_count_o}, {1'b1, 8'hB6, 3'd1});
        @(negedge clk);
        #1;
        chk("post_rst_empty", {a_valid_o, a_data_o, a_count_o}, 0);

        // Fill to full, fourth beat held upstream, then drain with no gaps
        b_src = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) b_step(1'b1, 1'b0);
        chk("full_held", 32'(b_src.size()), 1);
        for (int i = 0; i < 4; i++) begin
            b_step(1'b1, 1'b1);
            chk("drain_out_n", b_out_n, i + 1);
        end
        chk("drain_empty", 32'(b_sb.size()), 0);

        // Wrap-around with random handshakes
        b_out_n = 0;
        b_peak  = 0;
        for (int i = 0; i < 10; i++) b_src.push_back(8'(i));
        for (int k = 0; k < 400 && b_out_n < 10; k++) begin
            b_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("wrap_beats", b_out_n, 10);
        chk("wrap_peak_le3", 32'(b_peak <= 3), 1);

        // Registered mode: beat appears one cycle later, then 1 beat/cycle
        c_src = '{8'h55};
        c_step(1'b1, 1'b1);
        chk("reg_lat_n", c_out_n, 0);
        c_step(1'b1, 1'b1);
        chk("reg_lat_n1", c_out_n, 1);
        c_step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) c_src.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 9; i++) c_step(1'b1, 1'b1);
        chk("reg_throughput", c_out_n, 9);

`ifdef ELASTIC_BUFFER_STATS_EN
        b_valid_i = 1'b0; b_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b_cnt = 0; b_sb.delete(); b_src.delete();
        b_src = '{8'h77};
        b_step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) b_step(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stall7", b_stall, 7);
        chk("max1", 32'(b_max), 1);
        b_src = '{8'h88, 8'h99};
        b_step(1'b1, 1'b0);
        b_step(1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("stall9", b_stall, 9);
        chk("max3", 32'(b_max), 3);
        for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("stall_after_drain", b_stall, 9);
        chk("a_stats_idle", {a_stall, 5'd0, a_max}, 0);
        chk("c_stats_idle", {c_stall, 6'd0, c_max}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
Parametrised elastic buffer with a valid/ready handshake on both sides. It generalises the single-entry skid buffer to DEPTH entries and adds a selectable zero-latency bypass mode, an occupancy output, and a ready_o that never depends combinationally on ready_i. It sits between HWPE streamer ports and NVDLA CSB/DMA interfaces, where deeper slack or timing isolation is needed.

Parameters:
DW, 8, payload width in bits
DEPTH, 2, number of storage entries; must be >= 2; non-power-of-2 allowed
BYPASS, 1, 1 = data passes straight through when the buffer is empty (0-cycle latency); 0 = fully registered output (1-cycle latency)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  upstream valid
ready_o  output  1  upstream ready
data_i  input  DW  upstream payload
valid_o  output  1  downstream valid
ready_i  input  1  downstream ready
data_o  output  DW  downstream payload
count_o  output  $clog2(DEPTH+1)  current number of stored entries

Behaviour:
- Reset (rst_n low, asynchronous): pointers, count and storage cleared to 0.
  - valid_o=0, ready_o=0, data_o='0, count_o=0 for as long as rst_n is low, including the same cycle it asserts.
  - The first accept can occur on the first posedge after rst_n is released.
- Handshake and storage:
  - Push = valid_i && ready_o. Pop = valid_o && ready_i.
  - Storage is a circular buffer with wr_ptr and rd_ptr in 0..DEPTH-1; each pointer wraps from DEPTH-1 to 0 explicitly (no power-of-2 assumption).
- ready_o = rst_n && (count < DEPTH). It is a function of state only.
  - When full, no push is accepted even if a pop happens in the same cycle.
- BYPASS=1:
  - count==0 and valid_i: valid_o=1 and data_o=data_i combinationally.
  - If ready_i is also high, the beat passes through, is not written, and count is unchanged.
  - If ready_i is low, the beat is written at wr_ptr and count becomes 1.
  - count>0: valid_o=1 and data_o=mem[rd_ptr]. A new push goes to storage, preserving order.
- BYPASS=0:
  - valid_o = (count!=0) and data_o = mem[rd_ptr], so the output is registered.
  - A beat accepted on cycle N is visible on cycle N+1.
  - Throughput is 1 beat/cycle when DEPTH>=2.
- data_o='0 whenever valid_o=0.
- Count update: +1 on stored push only, -1 on pop from storage, unchanged on simultaneous store+pop or on bypass pass-through.
- Data stability: while valid_o && !ready_i, data_o and valid_o hold across cycles. Upstream valid_i changes never alter a stored head.
- Overflow/underflow cannot occur by construction. Writes only happen when count<DEPTH and reads only when count>0.

Optional Feature:
ELASTIC_BUFFER_STATS_EN:
- When defined, adds output stall_cnt_o [31:0]: a saturating counter (holds at 32'hFFFF_FFFF) of cycles with valid_o && !ready_i.
  - Also adds output max_count_o (same width as count_o): the high-water mark of count_o.
  - Both are cleared by rst_n.
- When undefined, neither port nor its logic exists; the interface is exactly as listed above.

Decomposition:
- Package elastic_buffer_pkg holds:
  - the function cnt_width(depth) returning $clog2(depth+1);
  - the pointer increment-with-wrap function;
  - localparam STAT_W=32.
- One sub-module, elastic_buffer_mem: DEPTH x DW register array with write-enable/address and asynchronous read, reset to '0.
- Control (pointers, count, bypass muxing) stays in elastic_buffer.

Test Plan:
1. Reset mid-traffic: DEPTH=4, fill 3 beats, pull rst_n low while not on a clock edge -> valid_o=0, ready_o=0, count_o=0 immediately. After release, the first pushed beat 8'hA5 is the first one out.
2. Bypass pass-through: BYPASS=1, empty, valid_i=1, data_i=8'h3C, ready_i=1 -> same cycle valid_o=1, data_o=8'h3C, count_o stays 0.
3. Fill to full: DEPTH=3, ready_i=0, push 8'h01,02,03 -> count_o=3, ready_o=0, 4th beat 8'h04 held upstream. Raise ready_i -> outputs 01,02,03,04 in order, no gaps.
4. Registered mode latency: BYPASS=0, push 8'h55 at cycle N with ready_i=1 -> valid_o=1, data_o=8'h55 at N+1 only. Continuous traffic yields 1 beat/cycle.
5. Wrap-around: DEPTH=3, stream 10 beats 0..9 with random ready_i/valid_i -> output sequence exactly 0..9. count_o never exceeds 3 and matches the scoreboard every cycle.
6. ELASTIC_BUFFER_STATS_EN: hold ready_i=0 for 7 cycles with valid_o=1 -> stall_cnt_o=7. max_count_o equals the peak occupancy reached.
